mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive dcache grants while icache waits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum granted cycles without ACK/RTY.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have icache-side inputs i_cyc 1, i_stb 1, i_we 1, i_sel 16, i_adr 28, i_dat_m 128: the icache wishbone master request.
REQ-006 SHALL have icache-side outputs i_ack 1, i_rty 1, i_dat_s 128: the icache wishbone slave response.
REQ-007 SHALL have dcache-side inputs d_cyc, d_stb, d_we, d_sel, d_adr, d_dat_m: the dcache request, same widths as REQ-005.
REQ-008 SHALL have dcache-side outputs d_ack, d_rty, d_dat_s: the dcache response, same widths as REQ-006.
REQ-009 SHALL have downstream outputs m_cyc, m_stb, m_we, m_sel, m_adr, m_dat_m: the request to the L2 port, same widths as REQ-005.
REQ-010 SHALL have downstream inputs m_ack 1, m_rty 1, m_dat_s 128: the L2 response.
REQ-011 SHALL have output timeout_err, 1: sticky flag, set when any transaction times out.

Function
REQ-012 SHALL implement an FSM with states IDLE, GRANT_I and GRANT_D.
REQ-013 IDLE: a requester is valid when its cyc&stb=1; with only one requester valid, go to that requester's GRANT state next cycle.
REQ-014 IDLE with both requesters valid: choose GRANT_D, unless starve_cnt==STARVE_LIMIT, then choose GRANT_I.
REQ-015 starve_cnt: +1 on entering GRANT_D while icache valid; cleared on entering GRANT_I; saturates at STARVE_LIMIT; width $clog2(STARVE_LIMIT+1).
REQ-016 Grant latency: a request first valid in IDLE at cycle N SHALL see m_cyc=m_stb=1 at cycle N+1.
REQ-017 In GRANT_x, m_* request outputs SHALL equal the granted port's inputs combinationally.
REQ-018 In IDLE, all m_* request outputs SHALL be 0.
REQ-019 m_ack, m_rty and m_dat_s SHALL route only to the granted port.
REQ-020 The non-granted port SHALL see ack=0 and rty=0, with dat_s=m_dat_s (don't-care).
REQ-021 m_ack or m_rty in GRANT_x SHALL return the FSM to IDLE next cycle; exactly one IDLE bubble cycle between grants.
REQ-022 Granted requester dropping cyc before ack: m_cyc=0 that same cycle (combinational), FSM returns to IDLE next cycle, no ack delivered.
REQ-023 Watchdog counts cycles in GRANT_x, cleared in IDLE.
REQ-024 When the watchdog reaches TIMEOUT_CYCLES-1 with no ack/rty, the arbiter SHALL:
- pulse rty to the granted port for 1 cycle;
- force m_cyc=0 that cycle;
- set timeout_err;
- go to IDLE.
REQ-025 m_ack and timeout in the same cycle: ack wins, no rty, timeout_err unchanged.
REQ-026 m_ack in IDLE (spurious) SHALL be ignored; neither port acked.

Reset
REQ-027 RST_N=0 SHALL asynchronously force:
- state=IDLE, starve_cnt=0, watchdog=0, timeout_err=0;
- all m_* request outputs 0, all ack/rty outputs 0.
REQ-028 Reset mid-transaction SHALL abandon it; no ack forwarded after RST_N rises; first grant follows REQ-013/014.
REQ-029 timeout_err SHALL clear only on reset.

Structure
REQ-030 Package mem_arb_pkg SHALL hold the state enum, data width 128, address width 28 and select width 16.
REQ-031 The watchdog SHALL be sub-module arb_watchdog: inputs clear/enable, output expired.

Verification
REQ-032 Single icache read at adr 0x0000010, L2 acks after 3 cycles -> m_cyc at N+1, i_ack on the 3rd granted cycle, i_dat_s=m_dat_s, d_ack=0 throughout.
REQ-033 Both requesting continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-034 dcache granted, d_cyc dropped after 2 cycles -> m_cyc=0 same cycle, IDLE next cycle, no d_ack.
REQ-035 TIMEOUT_CYCLES=8, L2 never acks icache -> i_rty pulse on granted cycle 8, timeout_err=1, pending dcache granted two cycles later.
REQ-036 RST_N low mid-GRANT_D, then released with icache requesting -> all outputs 0 during reset, GRANT_I one cycle after release.
REQ-037 m_ack on the timeout cycle -> ack delivered, no rty, timeout_err stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory arbiter.
//   DATA_W / ADDR_W / SEL_W : wishbone bus widths used on every port
//   arb_state_e             : arbiter FSM states
package mem_arb_pkg;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 28;
  localparam int SEL_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts cycles spent in a grant and flags the cycle on which
// the count reaches TIMEOUT_CYCLES-1.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count (arbiter idle)
//   enable     : advance the count (arbiter granted)
//   expired    : high during the last permitted granted cycle
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      // The arbiter always leaves the grant on the LAST cycle, so the count
      // never needs to advance beyond it.
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache wishbone masters onto a single L2 port.
// dcache has priority, but icache is granted after STARVE_LIMIT consecutive
// dcache grants taken while it was waiting. A watchdog retries and abandons
// any grant lasting TIMEOUT_CYCLES cycles without ack/rty.
//   clk, rst_n              : clock, asynchronous active-low reset
//   i_* (cyc..dat_m / ack..): icache master request / slave response
//   d_*                     : dcache master request / slave response
//   m_*                     : request to / response from the L2 port
//   timeout_err             : sticky, set by any watchdog timeout
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [ADDR_W-1:0] i_adr,
  input  logic [DATA_W-1:0] i_dat_m,
  output logic              i_ack,
  output logic              i_rty,
  output logic [DATA_W-1:0] i_dat_s,
  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [SEL_W-1:0]  d_sel,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_dat_m,
  output logic              d_ack,
  output logic              d_rty,
  output logic [DATA_W-1:0] d_dat_s,
  output logic              m_cyc,
  output logic              m_stb,
  output logic              m_we,
  output logic [SEL_W-1:0]  m_sel,
  output logic [ADDR_W-1:0] m_adr,
  output logic [DATA_W-1:0] m_dat_m,
  input  logic              m_ack,
  input  logic              m_rty,
  input  logic [DATA_W-1:0] m_dat_s,
  output logic              timeout_err
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e    state, next_state;
  logic [SW-1:0] starve_cnt, starve_next;

  logic i_valid, d_valid;
  logic granted_i, granted_d, in_idle;
  logic grant_cyc, expired, timeout_fire, grant_done;

  assign i_valid   = i_cyc & i_stb;
  assign d_valid   = d_cyc & d_stb;
  assign in_idle   = (state == IDLE);
  assign granted_i = (state == GRANT_I);
  assign granted_d = (state == GRANT_D);

  // A grant ends on any L2 response, on timeout, or when the owner abandons
  // the cycle. An L2 response in the timeout cycle takes precedence.
  assign grant_cyc    = (granted_i & i_cyc) | (granted_d & d_cyc);
  assign timeout_fire = expired & ~m_ack & ~m_rty;
  assign grant_done   = m_ack | m_rty | timeout_fire | ~grant_cyc;

  arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (in_idle),
    .enable  (~in_idle),
    .expired (expired)
  );

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the block leaves it unassigned (no latch).
  always_comb begin
    next_state  = state;
    starve_next = starve_cnt;
    case (state)
      IDLE: begin
        if (i_valid && (!d_valid || starve_cnt == STARVE_MAX)) begin
          next_state  = GRANT_I;
          starve_next = '0;
        end else if (d_valid) begin
          next_state = GRANT_D;
          // Reaching here with icache waiting implies starve_cnt is below
          // STARVE_MAX, so the increment cannot overflow the limit.
          if (i_valid) starve_next = starve_cnt + 1'b1;
        end
      end
      GRANT_I, GRANT_D: begin
        if (grant_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    m_sel   = '0;
    m_adr   = '0;
    m_dat_m = '0;
    if (granted_i) begin
      m_cyc   = i_cyc & ~timeout_fire;
      m_stb   = i_stb & ~timeout_fire;
      m_we    = i_we;
      m_sel   = i_sel;
      m_adr   = i_adr;
      m_dat_m = i_dat_m;
    end else if (granted_d) begin
      m_cyc   = d_cyc & ~timeout_fire;
      m_stb   = d_stb & ~timeout_fire;
      m_we    = d_we;
      m_sel   = d_sel;
      m_adr   = d_adr;
      m_dat_m = d_dat_m;
    end
  end

  // Ack only reaches an owner that still holds cyc; an abandoned cycle gets none.
  assign i_ack   = granted_i & i_cyc & m_ack;
  assign i_rty   = granted_i & (m_rty | timeout_fire);
  assign d_ack   = granted_d & d_cyc & m_ack;
  assign d_rty   = granted_d & (m_rty | timeout_fire);
  assign i_dat_s = m_dat_s;
  assign d_dat_s = m_dat_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state      <= next_state;
      starve_cnt <= starve_next;
      if (timeout_fire) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized phase, all cycles compared against a transaction-level model.
module tb_mem_arbiter;

  localparam int SL  = 4;
  localparam int TOC = 8;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    logic [27:0]  adr;
    logic [127:0] dat;
  } req_t;

  logic clk, rst_n;
  req_t ireq, dreq;
  logic m_ack, m_rty;
  logic [127:0] m_dat_s;

  logic i_ack, i_rty, d_ack, d_rty, m_cyc, m_stb, m_we, timeout_err;
  logic [127:0] i_dat_s, d_dat_s, m_dat_m;
  logic [15:0]  m_sel;
  logic [27:0]  m_adr;

  mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TOC)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cyc(ireq.cyc), .i_stb(ireq.stb), .i_we(ireq.we), .i_sel(ireq.sel),
    .i_adr(ireq.adr), .i_dat_m(ireq.dat),
    .i_ack(i_ack), .i_rty(i_rty), .i_dat_s(i_dat_s),
    .d_cyc(dreq.cyc), .d_stb(dreq.stb), .d_we(dreq.we), .d_sel(dreq.sel),
    .d_adr(dreq.adr), .d_dat_m(dreq.dat),
    .d_ack(d_ack), .d_rty(d_rty), .d_dat_s(d_dat_s),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
    .m_adr(m_adr), .m_dat_m(m_dat_m),
    .m_ack(m_ack), .m_rty(m_rty), .m_dat_s(m_dat_s),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus (0 none, 1 icache, 2 dcache), how many
  // granted cycles have elapsed, consecutive dcache wins while icache waited,
  // and the sticky timeout flag.
  int owner = 0, gcycles = 0, starve = 0;
  bit terr = 0;

  // Values sampled at the most recent negedge, for directed checks.
  logic         obs_m_cyc, obs_i_ack, obs_i_rty, obs_d_ack, obs_terr;
  logic [27:0]  obs_m_adr;
  logic [127:0] obs_i_dat_s;

  // One clock cycle: inputs are already driven; compare at negedge, advance
  // the model, return 1 time unit after the next rising edge.
  task automatic step();
    req_t g, e;
    bit   to, e_iack, e_irty, e_dack, e_drty, iv, dv;
    @(negedge clk);
    obs_m_cyc = m_cyc;  obs_m_adr = m_adr;  obs_i_ack = i_ack;
    obs_i_rty = i_rty;  obs_d_ack = d_ack;  obs_i_dat_s = i_dat_s;
    obs_terr  = timeout_err;
    if (!rst_n) begin
      owner = 0; gcycles = 0; starve = 0; terr = 0;
    end
    e = '0; g = '0; to = 0;
    e_iack = 0; e_irty = 0; e_dack = 0; e_drty = 0;
    if (owner != 0) begin
      g  = (owner == 1) ? ireq : dreq;
      to = (gcycles + 1 == TOC) && !m_ack && !m_rty;
      e  = g;
      if (to) begin
        e.cyc = 1'b0;
        e.stb = 1'b0;
      end
      if (owner == 1) begin
        e_iack = m_ack && g.cyc;
        e_irty = m_rty || to;
      end else begin
        e_dack = m_ack && g.cyc;
        e_drty = m_rty || to;
      end
    end
    check("m_req", {m_cyc, m_stb, m_we, m_sel, m_adr, m_dat_m}, e);
    check("i_resp", {i_ack, i_rty}, {e_iack, e_irty});
    check("d_resp", {d_ack, d_rty}, {e_dack, e_drty});
    check("i_dat_s", i_dat_s, m_dat_s);
    check("d_dat_s", d_dat_s, m_dat_s);
    check("timeout_err", timeout_err, terr);
    if (rst_n) begin
      if (owner == 0) begin
        iv = ireq.cyc && ireq.stb;
        dv = dreq.cyc && dreq.stb;
        gcycles = 0;
        if (iv && dv) begin
          if (starve >= SL) begin owner = 1; starve = 0; end
          else begin owner = 2; starve = starve + 1; end
        end else if (iv) begin
          owner = 1; starve = 0;
        end else if (dv) begin
          owner = 2;
        end
      end else if (m_ack || m_rty || to || !g.cyc) begin
        owner = 0; gcycles = 0;
      end else begin
        gcycles++;
      end
      if (to) terr = 1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic req_t mk_req(input logic [27:0] adr, input logic we);
    req_t r;
    r.cyc = 1'b1; r.stb = 1'b1; r.we = we; r.sel = 16'hffff; r.adr = adr;
    r.dat = {$urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  task automatic quiet();
    ireq = '0; dreq = '0; m_ack = 1'b0; m_rty = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit expired");
  end

  logic [127:0] rdata;
  logic [9:0]   order, exp_order;
  int           ng;
  logic         prev_cyc;

  initial begin
    rst_n = 1'b0;
    quiet();
    m_dat_s = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Single icache read, L2 acks on the third granted cycle.
    ireq = mk_req(28'h0000010, 1'b0);
    step();
    check("r32_idle_cycle", obs_m_cyc, 1'b0);
    step();
    check("r32_grant_lat", obs_m_cyc, 1'b1);
    step();
    rdata = {$urandom, $urandom, $urandom, $urandom};
    m_dat_s = rdata; m_ack = 1'b1;
    step();
    check("r32_i_ack", obs_i_ack, 1'b1);
    check("r32_i_dat_s", obs_i_dat_s, rdata);
    check("r32_d_ack", obs_d_ack, 1'b0);
    quiet();
    step();

    // Both requesting continuously: icache wins every fifth grant.
    do_reset();
    ireq = mk_req(28'h1111111, 1'b0);
    dreq = mk_req(28'h2222222, 1'b1);
    m_ack = 1'b1;
    ng = 0; prev_cyc = 1'b0; order = '0;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      step();
      if (obs_m_cyc && !prev_cyc) begin
        order[ng] = (obs_m_adr == ireq.adr);
        ng++;
      end
      prev_cyc = obs_m_cyc;
    end
    for (int k = 0; k < 10; k++) exp_order[k] = (k % 5 == 4);
    check("r33_n_grants", ng, 10);
    check("r33_order", order, exp_order);

    // dcache drops cyc on its third granted cycle.
    do_reset();
    dreq = mk_req(28'h0abcdef, 1'b1);
    step();
    step();
    step();
    dreq.cyc = 1'b0; m_ack = 1'b1;
    step();
    check("r34_m_cyc_drop", obs_m_cyc, 1'b0);
    check("r34_no_d_ack", obs_d_ack, 1'b0);
    m_ack = 1'b0;
    ireq = mk_req(28'h0000abc, 1'b0);
    step();
    check("r34_idle_after", obs_m_cyc, 1'b0);
    step();
    check("r34_next_grant", obs_m_adr, 28'h0000abc);

    // L2 never answers icache: retry pulse on granted cycle TOC.
    do_reset();
    ireq = mk_req(28'h0000040, 1'b0);
    step();
    dreq = mk_req(28'h0000080, 1'b1);
    for (int k = 1; k < TOC; k++) step();
    step();
    check("r35_i_rty", obs_i_rty, 1'b1);
    check("r35_m_cyc_forced", obs_m_cyc, 1'b0);
    ireq = '0;
    step();
    check("r35_timeout_err", obs_terr, 1'b1);
    check("r35_bubble", obs_m_cyc, 1'b0);
    step();
    check("r35_d_granted", obs_m_cyc, 1'b1);
    check("r35_d_adr", obs_m_adr, 28'h0000080);
    m_ack = 1'b1;
    step();
    quiet();
    step();

    // Ack arrives on the timeout cycle: ack wins.
    do_reset();
    ireq = mk_req(28'h0000100, 1'b0);
    step();
    for (int k = 1; k < TOC; k++) step();
    m_ack = 1'b1;
    step();
    check("r37_i_ack", obs_i_ack, 1'b1);
    check("r37_no_rty", obs_i_rty, 1'b0);
    quiet();
    step();
    check("r37_terr_clear", obs_terr, 1'b0);

    // Reset in the middle of a dcache grant.
    do_reset();
    dreq = mk_req(28'h0000200, 1'b1);
    step();
    step();
    check("r36_pre_grant", obs_m_cyc, 1'b1);
    rst_n = 1'b0;
    ireq = mk_req(28'h0000300, 1'b0);
    m_ack = 1'b1;
    step();
    check("r36_m_cyc_rst", obs_m_cyc, 1'b0);
    check("r36_d_ack_rst", obs_d_ack, 1'b0);
    step();
    rst_n = 1'b1;
    dreq = '0; m_ack = 1'b0;
    step();
    check("r36_idle_rel", obs_m_cyc, 1'b0);
    step();
    check("r36_i_grant", obs_m_cyc, 1'b1);
    check("r36_i_adr", obs_m_adr, 28'h0000300);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        ireq = mk_req(28'($urandom), 1'($urandom));
        ireq.cyc = ($urandom_range(0, 3) != 0);
        ireq.stb = ($urandom_range(0, 6) != 0);
        ireq.sel = 16'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        dreq = mk_req(28'($urandom), 1'($urandom));
        dreq.cyc = ($urandom_range(0, 3) != 0);
        dreq.stb = ($urandom_range(0, 6) != 0);
        dreq.sel = 16'($urandom);
      end
      m_ack   = ($urandom_range(0, 5) == 0);
      m_rty   = ($urandom_range(0, 15) == 0);
      m_dat_s = {$urandom, $urandom, $urandom, $urandom};
      rst_n   = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
